// File: rtl/multiplier_arbiter_if.sv
// ---------------------------------------------------------------------------
// multiplier_arbiter_if
// Requester-side bus of the shared multiplier arbiter.
//   req      : one request bit per requester, held until its done pulse
//   op_a/op_b: packed operands, slice i belongs to requester i
//   gnt      : one-hot grant, high from grant through the done cycle
//   done     : one-cycle completion pulse to the granted requester
//   result   : shared registered product, valid while any done bit is high
//   overflow : registered overflow, valid with done
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface multiplier_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*WORD_SIZE-1:0] op_a;
    logic [NUM_REQ*WORD_SIZE-1:0] op_b;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           done;
    logic [WORD_SIZE-1:0]         result;
    logic                         overflow;

    modport master (
        output req, op_a, op_b,
        input  gnt, done, result, overflow
    );

    modport slave (
        input  req, op_a, op_b,
        output gnt, done, result, overflow
    );
endinterface

// File: rtl/multiplier_arbiter.sv
// ---------------------------------------------------------------------------
// multiplier_arbiter
// Round-robin arbiter that shares one external multiplier among NUM_REQ
// requesters. A winner's operands are latched at grant, the multiplier is
// started with a one-cycle pulse, and its product is returned to the winner
// with a one-cycle done pulse.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   req_bus      : requester bus (multiplier_arbiter_if.slave)
//   busy         : high whenever the FSM is not IDLE
//   mul_start    : one-cycle start pulse to the multiplier
//   mul_a/mul_b  : registered operands to the multiplier
//   mul_result   : multiplier product
//   mul_overflow : multiplier overflow flag
//   mul_done     : multiplier completion flag
//   timeout_err  : sticky watchdog error flag
//
// Optional feature macro: MUL_ARB_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT_CYCLES; on expiry the requester
//               gets result 0 / overflow 1 and timeout_err latches until reset
//   undefined : WAIT waits indefinitely, timeout_err tied low
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation; round-robin search over req each cycle
// START | mul_start high for this single cycle
// WAIT  | waiting for mul_done (a mul_done seen during START is ignored)
// RESP  | done[winner] pulsed, gnt still held; returns to IDLE
// ---------------------------------------------------------------------------
module multiplier_arbiter #(
    parameter int WORD_SIZE      = 16,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    multiplier_arbiter_if.slave   req_bus,
    output logic                  busy,
    output logic                  mul_start,
    output logic [WORD_SIZE-1:0]  mul_a,
    output logic [WORD_SIZE-1:0]  mul_b,
    input  logic [WORD_SIZE-1:0]  mul_result,
    input  logic                  mul_overflow,
    input  logic                  mul_done,
    output logic                  timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [IDX_W-1:0]     last_q,      last_d;
    logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
    logic [NUM_REQ-1:0]   done_q,      done_d;
    logic                 mul_start_q, mul_start_d;
    logic [WORD_SIZE-1:0] mul_a_q,     mul_a_d;
    logic [WORD_SIZE-1:0] mul_b_q,     mul_b_d;
    logic [WORD_SIZE-1:0] result_q,    result_d;
    logic                 overflow_q,  overflow_d;

`ifdef MUL_ARB_TIMEOUT_EN
    logic [15:0]          wd_cnt_q,      wd_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
`endif

    // Round-robin search: first requester at or after last_q+1, wrapping.
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    int               pos;

    always_comb begin
        found   = 1'b0;
        win_idx = last_q;
        cand    = '0;
        pos     = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            pos = int'(last_q) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!found && req_bus.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
`ifdef MUL_ARB_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d          = START;
                    gnt_d[win_idx]   = 1'b1;
                    last_d           = win_idx;
                    mul_a_d          = req_bus.op_a[win_idx*WORD_SIZE +: WORD_SIZE];
                    mul_b_d          = req_bus.op_b[win_idx*WORD_SIZE +: WORD_SIZE];
                    // registered start: high exactly while in START
                    mul_start_d      = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (mul_done) begin
                    state_d    = RESP;
                    result_d   = mul_result;
                    overflow_d = mul_overflow;
                    done_d     = gnt_q;
`ifdef MUL_ARB_TIMEOUT_EN
                end else if (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    // last permitted WAIT cycle elapsed without a product
                    state_d       = RESP;
                    result_d      = '0;
                    overflow_d    = 1'b1;
                    done_d        = gnt_q;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            done_q      <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_bus.gnt      = gnt_q;
    assign req_bus.done     = done_q;
    assign req_bus.result   = result_q;
    assign req_bus.overflow = overflow_q;
    assign busy             = (state_q != IDLE);
    assign mul_start        = mul_start_q;
    assign mul_a            = mul_a_q;
    assign mul_b            = mul_b_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multiplier_arbiter
// Directed bench for multiplier_arbiter with a latency-8 multiplier model and
// a scoreboard of expected {requester, result, overflow} per done pulse.
// ---------------------------------------------------------------------------
module tb_multiplier_arbiter;

    localparam int WS  = 16;
    localparam int NR  = 4;
    localparam int TO  = 10;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          busy;
    logic          mul_start;
    logic [WS-1:0] mul_a;
    logic [WS-1:0] mul_b;
    logic [WS-1:0] mul_result = '0;
    logic          mul_overflow = 1'b0;
    logic          mul_done = 1'b0;
    logic          timeout_err;

    multiplier_arbiter_if #(.WORD_SIZE(WS), .NUM_REQ(NR)) bus ();

    multiplier_arbiter #(
        .WORD_SIZE(WS),
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_bus     (bus),
        .busy        (busy),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_result  (mul_result),
        .mul_overflow(mul_overflow),
        .mul_done    (mul_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    typedef struct {
        int          idx;
        logic [WS-1:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    // multiplier model controls
    logic early_done = 1'b0;
    logic never_done = 1'b0;
    logic force_ovf  = 1'b0;
    int   mcnt       = 0;
    logic [2*WS-1:0] mprod = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [WS-1:0] a, input logic [WS-1:0] b,
                            input logic fovf);
        exp_t e;
        logic [2*WS-1:0] p;
        p     = {{WS{1'b0}}, a} * {{WS{1'b0}}, b};
        e.idx = idx;
        e.res = p[WS-1:0];
        e.ovf = (p[2*WS-1:WS] != '0) | fovf;
        sb.push_back(e);
    endtask

    task automatic set_ops(input int i, input logic [WS-1:0] a, input logic [WS-1:0] b);
        bus.op_a[i*WS +: WS] = a;
        bus.op_b[i*WS +: WS] = b;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (mul_start !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check(tag, 32'(mul_start), 32'h1);
    endtask

    // returns number of steps taken until the done counter reaches target
    task automatic wait_ndone(input string tag, input int target, output int k);
        k = 0;
        while (n_done < target && k < 120) begin
            step();
            k++;
        end
        check(tag, 32'(n_done), 32'(target));
    endtask

    // multiplier model: product returned LAT WAIT cycles after mul_start
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            mcnt     = 0;
            mul_done = 1'b0;
        end else if (mul_start === 1'b1) begin
            mprod        = {{WS{1'b0}}, mul_a} * {{WS{1'b0}}, mul_b};
            mcnt         = LAT;
            mul_result   = 16'hDEAD;
            mul_overflow = 1'b0;
            mul_done     = early_done;
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0 && !never_done) begin
                mul_result   = mprod[WS-1:0];
                mul_overflow = (mprod[2*WS-1:WS] != '0) | force_ovf;
                mul_done     = 1'b1;
            end else begin
                mul_done = 1'b0;
            end
        end else begin
            mul_done = 1'b0;
        end
    end

    // scoreboard monitor: every done pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done !== '0) begin
            n_done++;
            if (sb.size() == 0) begin
                check("done_unexpected", 32'(bus.done), 32'h0);
            end else begin
                e_mon = sb.pop_front();
                check("done_onehot", 32'(bus.done), 32'(1 << e_mon.idx));
                check("gnt_in_resp", 32'(bus.gnt), 32'(1 << e_mon.idx));
                check("result", 32'(bus.result), 32'(e_mon.res));
                check("overflow", 32'(bus.overflow), 32'(e_mon.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int base;

        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;

        // reset state
        step();
        step();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mul_start", 32'(mul_start), 32'h0);
        check("rst_mul_a", 32'(mul_a), 32'h0);
        check("rst_mul_b", 32'(mul_b), 32'h0);
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst = 1'b1;
        step();

        // single request 3*5, operands changed after grant
        set_ops(0, 16'd3, 16'd5);
        push_exp(0, 16'd3, 16'd5, 1'b0);
        bus.req = 4'b0001;
        step();
        check("lat_mul_start", 32'(mul_start), 32'h1);
        check("first_gnt", 32'(bus.gnt), 32'h1);
        check("first_busy", 32'(busy), 32'h1);
        check("first_mul_a", 32'(mul_a), 32'd3);
        check("first_mul_b", 32'(mul_b), 32'd5);
        set_ops(0, 16'd7, 16'd9);
        step();
        check("start_one_cycle", 32'(mul_start), 32'h0);
        check("mul_a_stable", 32'(mul_a), 32'd3);
        k = 0;
        while (mul_done !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("model_done_seen", 32'(mul_done), 32'h1);
        check("done_before_mul_done", 32'(bus.done), 32'h0);
        step();
        check("lat_done", 32'(bus.done), 32'h1);
        check("lat_result", 32'(bus.result), 32'd15);
        bus.req = 4'b0000;
        step();
        check("idle_done", 32'(bus.done), 32'h0);
        check("idle_gnt", 32'(bus.gnt), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("result_hold", 32'(bus.result), 32'd15);
        check("first_ndone", 32'(n_done), 32'd1);

        // all four requesting after reset: order 0,1,2,3,0
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        set_ops(0, 16'd300, 16'd300);
        set_ops(1, 16'd12, 16'd11);
        set_ops(2, 16'd1000, 16'd65);
        set_ops(3, 16'hFFFF, 16'd1);
        push_exp(0, 16'd300, 16'd300, 1'b0);
        push_exp(1, 16'd12, 16'd11, 1'b0);
        push_exp(2, 16'd1000, 16'd65, 1'b0);
        push_exp(3, 16'hFFFF, 16'd1, 1'b0);
        push_exp(0, 16'd300, 16'd300, 1'b0);
        base = n_done;
        bus.req = 4'b1111;
        wait_ndone("rr_five_done", base + 5, k);
        bus.req = 4'b0000;
        step();
        step();
        check("rr_idle", 32'(busy), 32'h0);
        check("rr_sb_empty", 32'(sb.size()), 32'h0);

        // mul_done during START must be ignored
        early_done = 1'b1;
        set_ops(1, 16'd123, 16'd45);
        push_exp(1, 16'd123, 16'd45, 1'b0);
        base = n_done;
        bus.req = 4'b0010;
        wait_start("early_start");
        wait_ndone("early_done", base + 1, k);
        check("early_latency", 32'(k), 32'd9);
        bus.req = 4'b0000;
        early_done = 1'b0;
        step();
        step();
        step();
        check("early_single_done", 32'(n_done), 32'(base + 1));

        // reset during WAIT of requester 2
        set_ops(2, 16'd7, 16'd8);
        base = n_done;
        bus.req = 4'b0100;
        wait_start("rstmid_start");
        check("rstmid_gnt", 32'(bus.gnt), 32'h4);
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        check("rstmid_gnt0", 32'(bus.gnt), 32'h0);
        check("rstmid_done0", 32'(bus.done), 32'h0);
        check("rstmid_busy0", 32'(busy), 32'h0);
        check("rstmid_mul_start0", 32'(mul_start), 32'h0);
        check("rstmid_mul_a0", 32'(mul_a), 32'h0);
        check("rstmid_mul_b0", 32'(mul_b), 32'h0);
        check("rstmid_result0", 32'(bus.result), 32'h0);
        check("rstmid_overflow0", 32'(bus.overflow), 32'h0);
        step();
        step();
        check("rstmid_no_done", 32'(n_done), 32'(base));
        push_exp(2, 16'd7, 16'd8, 1'b0);
        rst = 1'b1;
        wait_ndone("rstmid_regrant", base + 1, k);
        bus.req = 4'b0000;
        step();

        // requester 1 drops req during WAIT, overflow forced by the model
        force_ovf = 1'b1;
        set_ops(1, 16'd100, 16'd200);
        push_exp(1, 16'd100, 16'd200, 1'b1);
        base = n_done;
        bus.req = 4'b0010;
        wait_start("drop_start");
        check("drop_gnt", 32'(bus.gnt), 32'h2);
        step();
        step();
        bus.req = 4'b0000;
        wait_ndone("drop_done", base + 1, k);
        force_ovf = 1'b0;
        set_ops(0, 16'd2, 16'd3);
        set_ops(2, 16'd5, 16'd6);
        set_ops(3, 16'd9, 16'd9);
        push_exp(2, 16'd5, 16'd6, 1'b0);
        bus.req = 4'b1101;
        wait_ndone("after_drop_done", base + 2, k);
        bus.req = 4'b0000;
        step();
        step();
        check("after_drop_idle", 32'(busy), 32'h0);

`ifdef MUL_ARB_TIMEOUT_EN
        // watchdog: model never returns mul_done
        never_done = 1'b1;
        set_ops(0, 16'd3, 16'd3);
        begin
            exp_t et;
            et.idx = 0;
            et.res = '0;
            et.ovf = 1'b1;
            sb.push_back(et);
        end
        base = n_done;
        bus.req = 4'b0001;
        wait_start("to_start");
        wait_ndone("to_done", base + 1, k);
        check("to_latency", 32'(k), 32'(TO + 1));
        check("to_err_set", 32'(timeout_err), 32'h1);
        bus.req = 4'b0000;
        never_done = 1'b0;
        step();
        step();
        step();
        check("to_err_sticky", 32'(timeout_err), 32'h1);
        rst = 1'b0;
        #1;
        check("to_err_cleared", 32'(timeout_err), 32'h0);
        step();
        rst = 1'b1;
        step();
`else
        check("no_watchdog_err", 32'(timeout_err), 32'h0);
`endif

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, operand/result width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  request per requester; held high until its done pulse.
REQ-007 op_a  input  NUM_REQ*WORD_SIZE  packed operand A, slice i belongs to requester i.
REQ-008 op_b  input  NUM_REQ*WORD_SIZE  packed operand B, slice i belongs to requester i.
REQ-009 gnt  output  NUM_REQ  one-hot grant, high from grant through done cycle.
REQ-010 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 result  output  WORD_SIZE  shared registered product, valid while any done bit high.
REQ-012 overflow  output  1  registered overflow, valid with done.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-015 mul_a, mul_b  output  WORD_SIZE each  registered operands to the multiplier.
REQ-016 mul_result  input  WORD_SIZE  multiplier product.
REQ-017 mul_overflow  input  1  multiplier overflow flag.
REQ-018 mul_done  input  1  multiplier completion flag.
REQ-019 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-021 IDLE: any req bit high at the edge -> winner chosen round-robin, gnt[winner] set, operands latched into mul_a/mul_b, go to START; otherwise stay.
REQ-022 Round-robin search SHALL begin at last_winner+1 and wrap modulo NUM_REQ; last_winner updates at each grant.
REQ-023 START: mul_start high exactly one cycle, then WAIT.
REQ-024 WAIT: mul_done sampled from the first WAIT cycle onward; mul_done during START ignored.
REQ-025 On mul_done in WAIT: result/overflow registered from mul_result/mul_overflow, go to RESP.
REQ-026 RESP: done[winner] high one cycle, gnt held; next state IDLE with gnt cleared.
REQ-027 Latency req-sample to mul_start = 1 cycle; mul_done-sample to done = 1 cycle.
REQ-028 req still high in IDLE after done SHALL be treated as a new request.
REQ-029 req dropped mid-operation: operation completes, done still pulsed, pointer still advanced.
REQ-030 op_a/op_b changes after grant SHALL NOT affect mul_a/mul_b.
REQ-031 result/overflow SHALL hold last value outside RESP; done/mul_start zero outside their states.

Reset
REQ-032 rst low SHALL immediately force IDLE; gnt, done, busy, mul_start, mul_a, mul_b, result, overflow, timeout_err all zero.
REQ-033 Reset SHALL set last_winner to NUM_REQ-1 so requester 0 wins first.
REQ-034 Reset mid-operation SHALL abandon the operation with no done pulse.

Configuration
REQ-035 Macro MUL_ARB_TIMEOUT_EN defined: 16-bit counter cleared on entering WAIT, increments each WAIT cycle; reaching TIMEOUT_CYCLES without mul_done -> RESP with result 0, overflow 1, timeout_err set sticky until reset.
REQ-036 Macro MUL_ARB_TIMEOUT_EN undefined: no counter, WAIT waits indefinitely, timeout_err tied 0.

Verification
REQ-037 Multiplier model latency 8; req=4'b0001, op_a0=3, op_b0=5, model returns 15 -> mul_start 1 cycle after req, done=4'b0001 with result=15, overflow=0.
REQ-038 req=4'b1111 held after reset -> grant order 0,1,2,3,0; each grant waits for prior done.
REQ-039 Model asserts mul_done in START cycle then again at latency 8 -> first pulse ignored, single done at latency 8.
REQ-040 rst low during WAIT of requester 2 -> all outputs 0 immediately, no done; next req=4'b0100 granted normally.
REQ-041 MUL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, model never returns done -> done pulse after 10 WAIT cycles, result=0, overflow=1, timeout_err=1 until reset.
REQ-042 req1 dropped during WAIT, model overflow=1 -> done[1] still pulses with overflow=1; next grant searches from requester 2.
